// File: rtl/mult_seq_ctl_dp.sv
// Sequential shift-add multiplier (unsigned / two's-complement) with a counter-driven control FSM.
// The product is left in {A,B}; X holds the sign extension (signed) or the add carry (unsigned).
module mult_seq_ctl_dp #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clear_a_load_b,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             x_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADD,
        SHIFT,
        HALT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic [WIDTH-1:0] regS;
    logic             regX;
    logic             mode;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   opA;
    logic [WIDTH:0]   opS;
    logic [WIDTH:0]   sum;
    logic             isLast;

    // Adder: sign-extended in signed mode; the final partial product of a signed multiplier is negative.
    always_comb begin
        isLast = (cnt == LAST_CNT);
        opA    = mode ? {regA[WIDTH-1], regA} : {1'b0, regA};
        opS    = mode ? {regS[WIDTH-1], regS} : {1'b0, regS};
        sum    = (mode && isLast) ? (opA - opS) : (opA + opS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            regA  <= '0;
            regB  <= '0;
            regS  <= '0;
            regX  <= 1'b0;
            mode  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (clear_a_load_b) begin
                        regA <= '0;
                        regX <= 1'b0;
                        regB <= sw;
                    end else if (run) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    regS  <= sw;
                    mode  <= signed_mode;
                    regA  <= '0;
                    regX  <= 1'b0;
                    cnt   <= '0;
                    state <= regB[0] ? ADD : SHIFT;
                end
                ADD: begin
                    {regX, regA} <= sum;
                    state        <= SHIFT;
                end
                SHIFT: begin
                    regA <= {regX, regA[WIDTH-1:1]};
                    regB <= {regA[0], regB[WIDTH-1:1]};
                    if (!mode) begin
                        regX <= 1'b0;
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (isLast) begin
                        state <= HALT;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        // regB[1] becomes the next multiplier bit after this shift
                        state <= regB[1] ? ADD : SHIFT;
                    end
                end
                HALT: begin
                    if (!run) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign a_out = regA;
    assign b_out = regB;
    assign x_out = regX;

endmodule

// File: tb/tb_mult_seq_ctl_dp.sv
// Bench for mult_seq_ctl_dp: 8-bit and 4-bit instances, integer-product reference model and scoreboards.
module tb_mult_seq_ctl_dp;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        x;
        int          lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0, clr = 1'b0, sgn = 1'b0;
    logic [7:0] sw = '0;
    logic [7:0] aOut, bOut;
    logic       xOut, busy, done;
    logic       run4 = 1'b0, clr4 = 1'b0, sgn4 = 1'b0;
    logic [3:0] sw4 = '0;
    logic [3:0] aOut4, bOut4;
    logic       xOut4, busy4, done4;

    int   errors = 0;
    int   checks = 0;
    exp_t q8[$];
    exp_t q4[$];
    logic [7:0] modelB = '0;
    logic [3:0] modelB4 = '0;

    always #5 clk = ~clk;

    mult_seq_ctl_dp #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .run(run), .clear_a_load_b(clr), .signed_mode(sgn), .sw(sw),
        .a_out(aOut), .b_out(bOut), .x_out(xOut), .busy(busy), .done(done)
    );

    mult_seq_ctl_dp #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .run(run4), .clear_a_load_b(clr4), .signed_mode(sgn4), .sw(sw4),
        .a_out(aOut4), .b_out(bOut4), .x_out(xOut4), .busy(busy4), .done(done4)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer product of the two operands, split into halves.
    function automatic exp_t model(input int w, input logic [31:0] s, input logic [31:0] b, input logic m);
        exp_t   e;
        longint mask;
        longint sv;
        longint bv;
        longint p;
        mask = (longint'(1) << w) - 1;
        sv = longint'(s) & mask;
        bv = longint'(b) & mask;
        if (m && sv[w-1]) sv = sv - (longint'(1) << w);
        if (m && bv[w-1]) bv = bv - (longint'(1) << w);
        p = sv * bv;
        e.a = 32'((p >>> w) & mask);
        e.b = 32'(p & mask);
        e.x = m ? e.a[w-1] : 1'b0;
        e.lat = 1 + w + $countones(b & 32'(mask));
        return e;
    endfunction

    // Monitors: pop an expectation whenever a DUT enters HALT; latency measured from busy rising.
    int cyc8 = 0, st8 = 0, cyc4 = 0, st4 = 0;
    logic pBusy8 = 1'b0, pDone8 = 1'b0, pBusy4 = 1'b0, pDone4 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc8++;
        if (busy && !pBusy8) st8 = cyc8;
        if (done && !pDone8) begin
            if (q8.size() == 0) begin
                check("w8_unexpected_done", 64'(q8.size()), 64'd1);
            end else begin
                e = q8.pop_front();
                check("w8_a", 64'(aOut), 64'(e.a));
                check("w8_b", 64'(bOut), 64'(e.b));
                check("w8_x", 64'(xOut), 64'(e.x));
                check("w8_latency", 64'(cyc8 - st8), 64'(e.lat));
            end
        end
        pBusy8 = busy;
        pDone8 = done;
    end

    always @(negedge clk) begin
        exp_t e;
        cyc4++;
        if (busy4 && !pBusy4) st4 = cyc4;
        if (done4 && !pDone4) begin
            if (q4.size() == 0) begin
                check("w4_unexpected_done", 64'(q4.size()), 64'd1);
            end else begin
                e = q4.pop_front();
                check("w4_a", 64'(aOut4), 64'(e.a));
                check("w4_b", 64'(bOut4), 64'(e.b));
                check("w4_x", 64'(xOut4), 64'(e.x));
                check("w4_latency", 64'(cyc4 - st4), 64'(e.lat));
            end
        end
        pBusy4 = busy4;
        pDone4 = done4;
    end

    task automatic loadB(input logic [7:0] v);
        clr = 1'b1;
        sw = v;
        @(negedge clk);
        clr = 1'b0;
        modelB = v;
    endtask

    // Waits for HALT, optionally holds run there, then releases run and expects IDLE.
    task automatic finishMul(input exp_t e, input int holdHalt);
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        check("w8_done_timeout", 64'(done), 64'd1);
        repeat (holdHalt) @(negedge clk);
        check("w8_halt_hold_done", 64'(done), 64'd1);
        check("w8_halt_hold_busy", 64'(busy), 64'd0);
        check("w8_halt_hold_a", 64'(aOut), 64'(e.a));
        run = 1'b0;
        @(negedge clk);
        check("w8_release_done", 64'(done), 64'd0);
        modelB = e.b[7:0];
    endtask

    task automatic doMul(input logic [7:0] s, input logic m, input int holdHalt, input bit pulseClr);
        exp_t e;
        e = model(8, 32'(s), 32'(modelB), m);
        q8.push_back(e);
        sw = s;
        sgn = m;
        run = 1'b1;
        if (pulseClr) begin
            repeat (4) @(negedge clk);
            clr = 1'b1;
            sw = ~s;
            @(negedge clk);
            clr = 1'b0;
        end
        finishMul(e, holdHalt);
    endtask

    task automatic doMul4(input logic [3:0] b, input logic [3:0] s, input logic m);
        exp_t e;
        clr4 = 1'b1;
        sw4 = b;
        @(negedge clk);
        clr4 = 1'b0;
        modelB4 = b;
        e = model(4, 32'(s), 32'(modelB4), m);
        q4.push_back(e);
        sw4 = s;
        sgn4 = m;
        run4 = 1'b1;
        for (int i = 0; i < 60 && !done4; i++) @(negedge clk);
        check("w4_done_timeout", 64'(done4), 64'd1);
        run4 = 1'b0;
        @(negedge clk);
        check("w4_release_done", 64'(done4), 64'd0);
    endtask

    initial begin
        exp_t e;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_a", 64'(aOut), 64'd0);
        check("reset_b", 64'(bOut), 64'd0);
        check("reset_x", 64'(xOut), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);

        // Directed cases: unsigned max, follow-on run with held run, signed incl. final-bit subtract
        loadB(8'hFF);
        doMul(8'hFF, 1'b0, 0, 1'b0);
        doMul(8'h02, 1'b0, 6, 1'b0);
        loadB(8'hFD);
        doMul(8'h07, 1'b1, 1, 1'b0);
        loadB(8'hFF);
        doMul(8'hFF, 1'b1, 0, 1'b0);
        loadB(8'hB6);
        doMul(8'h5B, 1'b0, 0, 1'b1);

        // Load and run in the same cycle: load only, start follows while run stays high
        clr = 1'b1;
        run = 1'b1;
        sw = 8'h93;
        sgn = 1'b1;
        modelB = 8'h93;
        e = model(8, 32'h0000_0011, 32'h0000_0093, 1'b1);
        q8.push_back(e);
        @(negedge clk);
        check("ldrun_busy", 64'(busy), 64'd0);
        check("ldrun_b", 64'(bOut), 64'h93);
        clr = 1'b0;
        sw = 8'h11;
        finishMul(e, 0);

        loadB(8'h00);
        doMul(8'hC3, 1'b0, 0, 1'b0);

        // Reset mid-operation aborts and clears everything
        loadB(8'hA5);
        sw = 8'h33;
        run = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("abort_a", 64'(aOut), 64'd0);
        check("abort_b", 64'(bOut), 64'd0);
        check("abort_x", 64'(xOut), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        modelB = 8'h00;
        doMul(8'h7E, 1'b1, 0, 1'b0);

        // Randomized operations, B sometimes reloaded and sometimes carried over
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) loadB(8'($urandom));
            doMul(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  $urandom_range(0, 3) == 0);
        end

        // 4-bit instance
        doMul4(4'h8, 4'h8, 1'b1);
        doMul4(4'hF, 4'hF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            doMul4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("w8_queue_empty", 64'(q8.size()), 64'd0);
        check("w4_queue_empty", 64'(q4.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
